// File: rtl/gmii_tx.sv
// rtl/gmii_tx.sv - GMII transmit MAC: FWFT frame FIFO to PHY with preamble, pad, FCS and IFG
module crc32_d8 (
    input  logic [31:0] crc_in,
    input  logic [7:0]  data,
    output logic [31:0] crc_out
);
    logic [31:0] c;

    // Reflected CRC-32, bytes consumed LSB first as they appear on the wire
    always_comb begin
        c = crc_in;
        for (int i = 0; i < 8; i++) begin
            if (c[0] ^ data[i]) c = (c >> 1) ^ 32'hEDB88320;
            else                c = c >> 1;
        end
        crc_out = c;
    end
endmodule

module gmii_tx #(
    parameter bit PAD_EN  = 1'b1,
    parameter int MIN_LEN = 60,
    parameter int IFG_LEN = 12
) (
    input  logic       phy_tx_clk,
    input  logic       sys_rst,
    input  logic [8:0] rd_data,
    input  logic       rd_empty,
    output logic       rd_en,
    output logic       phy_tx_en,
    output logic       phy_tx_er,
    output logic [7:0] phy_txd,
    output logic       tx_busy,
    output logic       tx_underrun
);
    typedef enum logic [2:0] {IDLE, PREAMBLE, SFD, DATA, PAD, FCS, IFG, DRAIN} state_t;

    localparam logic [10:0] MIN_LEN_W = 11'(MIN_LEN);
    localparam logic [7:0]  IFG_LAST  = 8'(IFG_LEN - 1);

    state_t      state, state_nxt;
    logic [2:0]  pre_cnt, pre_cnt_nxt;
    logic [10:0] byte_cnt, byte_cnt_nxt, cnt_inc;
    logic [1:0]  fcs_idx, fcs_idx_nxt;
    logic [7:0]  ifg_cnt, ifg_cnt_nxt;
    logic [31:0] crc, crc_nxt, crc_fold;
    logic [7:0]  fold_byte;
    logic        head_data, head_marker, pad_needed;
    logic        tx_en_nxt, tx_er_nxt, underrun_nxt, busy_nxt;
    logic [7:0]  txd_nxt;

    function automatic logic [7:0] fcs_byte(input logic [31:0] c, input logic [1:0] idx);
        logic [31:0] t;
        t = ~c >> {idx, 3'b000};
        return t[7:0];
    endfunction

    assign head_data   = !rd_empty &&  rd_data[8];
    assign head_marker = !rd_empty && !rd_data[8];
    assign cnt_inc     = (byte_cnt == 11'd2047) ? byte_cnt : byte_cnt + 11'd1;
    assign pad_needed  = PAD_EN && (byte_cnt < MIN_LEN_W);
    assign fold_byte   = (state == DATA && head_data) ? rd_data[7:0] : 8'h00;

    crc32_d8 u_crc (
        .crc_in  (crc),
        .data    (fold_byte),
        .crc_out (crc_fold)
    );

    always_ff @(posedge phy_tx_clk) begin
        if (sys_rst) begin
            state       <= IDLE;
            pre_cnt     <= '0;
            byte_cnt    <= '0;
            fcs_idx     <= '0;
            ifg_cnt     <= '0;
            crc         <= 32'hFFFFFFFF;
            phy_tx_en   <= 1'b0;
            phy_tx_er   <= 1'b0;
            phy_txd     <= 8'h00;
            tx_busy     <= 1'b0;
            tx_underrun <= 1'b0;
        end else begin
            state       <= state_nxt;
            pre_cnt     <= pre_cnt_nxt;
            byte_cnt    <= byte_cnt_nxt;
            fcs_idx     <= fcs_idx_nxt;
            ifg_cnt     <= ifg_cnt_nxt;
            crc         <= crc_nxt;
            phy_tx_en   <= tx_en_nxt;
            phy_tx_er   <= tx_er_nxt;
            phy_txd     <= txd_nxt;
            tx_busy     <= busy_nxt;
            tx_underrun <= underrun_nxt;
        end
    end

    // The line registers hold the byte chosen in the current state, so the
    // first preamble byte is already committed on the IDLE->PREAMBLE edge.
    always_comb begin
        state_nxt    = state;
        pre_cnt_nxt  = pre_cnt;
        byte_cnt_nxt = byte_cnt;
        fcs_idx_nxt  = fcs_idx;
        ifg_cnt_nxt  = ifg_cnt;
        crc_nxt      = crc;
        case (state)
            IDLE: if (head_data) begin
                state_nxt   = PREAMBLE;
                pre_cnt_nxt = 3'd1;
            end
            PREAMBLE: if (pre_cnt == 3'd6) state_nxt = SFD;
                      else pre_cnt_nxt = pre_cnt + 3'd1;
            SFD: begin
                state_nxt    = DATA;
                crc_nxt      = 32'hFFFFFFFF;
                byte_cnt_nxt = '0;
            end
            DATA: begin
                if (head_data) begin
                    crc_nxt      = crc_fold;
                    byte_cnt_nxt = cnt_inc;
                end else if (head_marker) begin
                    if (pad_needed) begin
                        crc_nxt      = crc_fold;
                        byte_cnt_nxt = cnt_inc;
                        fcs_idx_nxt  = 2'd0;
                        state_nxt    = (cnt_inc >= MIN_LEN_W) ? FCS : PAD;
                    end else begin
                        fcs_idx_nxt = 2'd1;
                        state_nxt   = FCS;
                    end
                end else begin
                    state_nxt = DRAIN;
                end
            end
            PAD: begin
                crc_nxt      = crc_fold;
                byte_cnt_nxt = cnt_inc;
                if (cnt_inc >= MIN_LEN_W) begin
                    fcs_idx_nxt = 2'd0;
                    state_nxt   = FCS;
                end
            end
            FCS: if (fcs_idx == 2'd3) begin
                state_nxt   = IFG;
                ifg_cnt_nxt = '0;
            end else begin
                fcs_idx_nxt = fcs_idx + 2'd1;
            end
            IFG: if (ifg_cnt == IFG_LAST) state_nxt = IDLE;
                 else ifg_cnt_nxt = ifg_cnt + 8'd1;
            DRAIN: if (head_marker) begin
                state_nxt   = IFG;
                ifg_cnt_nxt = '0;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        rd_en        = 1'b0;
        tx_en_nxt    = 1'b0;
        tx_er_nxt    = 1'b0;
        txd_nxt      = 8'h00;
        underrun_nxt = 1'b0;
        case (state)
            IDLE: begin
                rd_en = head_marker;
                if (head_data) begin
                    tx_en_nxt = 1'b1;
                    txd_nxt   = 8'h55;
                end
            end
            PREAMBLE: begin
                tx_en_nxt = 1'b1;
                txd_nxt   = 8'h55;
            end
            SFD: begin
                tx_en_nxt = 1'b1;
                txd_nxt   = 8'hD5;
            end
            DATA: begin
                rd_en     = !rd_empty;
                tx_en_nxt = 1'b1;
                if (head_data)        txd_nxt = rd_data[7:0];
                else if (head_marker) txd_nxt = pad_needed ? 8'h00 : fcs_byte(crc, 2'd0);
                else begin
                    tx_er_nxt    = 1'b1;
                    underrun_nxt = 1'b1;
                end
            end
            PAD: tx_en_nxt = 1'b1;
            FCS: begin
                tx_en_nxt = 1'b1;
                txd_nxt   = fcs_byte(crc, fcs_idx);
            end
            DRAIN: rd_en = !rd_empty;
            default: ;
        endcase
        busy_nxt = (state != IDLE) || (state_nxt != IDLE);
    end
endmodule

// File: tb/tb_gmii_tx.sv
// tb/tb_gmii_tx.sv - Scoreboard bench for gmii_tx with padded and unpadded instances
module tb_gmii_tx;
    logic phy_tx_clk = 1'b0;
    logic sys_rst    = 1'b1;
    always #4 phy_tx_clk = ~phy_tx_clk;

    logic [8:0] rd_data0, rd_data1;
    logic       rd_empty0, rd_en0, tx_en0, tx_er0, tx_busy0, tx_und0;
    logic       rd_empty1, rd_en1, tx_en1, tx_er1, tx_busy1, tx_und1;
    logic [7:0] txd0, txd1;

    gmii_tx #(.PAD_EN(1'b1), .MIN_LEN(60), .IFG_LEN(12)) dut (
        .phy_tx_clk(phy_tx_clk), .sys_rst(sys_rst), .rd_data(rd_data0), .rd_empty(rd_empty0),
        .rd_en(rd_en0), .phy_tx_en(tx_en0), .phy_tx_er(tx_er0), .phy_txd(txd0),
        .tx_busy(tx_busy0), .tx_underrun(tx_und0));

    gmii_tx #(.PAD_EN(1'b0), .MIN_LEN(60), .IFG_LEN(12)) dut_np (
        .phy_tx_clk(phy_tx_clk), .sys_rst(sys_rst), .rd_data(rd_data1), .rd_empty(rd_empty1),
        .rd_en(rd_en1), .phy_tx_en(tx_en1), .phy_tx_er(tx_er1), .phy_txd(txd1),
        .tx_busy(tx_busy1), .tx_underrun(tx_und1));

    logic [8:0] mem0 [0:1023];
    logic [8:0] mem1 [0:1023];
    int h0 = 0, t0 = 0, h1 = 0, t1 = 0, rd_cnt0 = 0;
    assign rd_data0  = mem0[h0[9:0]];
    assign rd_empty0 = (h0 == t0);
    assign rd_data1  = mem1[h1[9:0]];
    assign rd_empty1 = (h1 == t1);

    always @(posedge phy_tx_clk) begin
        if (sys_rst) begin
            h0 <= t0;
            h1 <= t1;
        end else begin
            if (rd_en0) begin
                h0      <= h0 + 1;
                rd_cnt0 <= rd_cnt0 + 1;
            end
            if (rd_en1) h1 <= h1 + 1;
        end
    end

    int n_vec = 0, n_miss = 0;
    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    function automatic logic [31:0] crc_step(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        r = c;
        for (int i = 0; i < 8; i++) begin
            if (r[31] ^ d[i]) r = {r[30:0], 1'b0} ^ 32'h04C11DB7;
            else              r = {r[30:0], 1'b0};
        end
        return r;
    endfunction

    function automatic logic [7:0] rev8(input logic [7:0] b);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[i] = b[7-i];
        return r;
    endfunction

    logic [8:0] exp_q[$];
    logic [7:0] pl[$];
    int run_q[$], gap_q[$], gap_busy_q[$], run1_q[$];
    int run_len = 0, gap_len = 0, und_cnt = 0, stray_er = 0, run_len1 = 0;
    bit in_run = 0, have_prev = 0, er_in_run = 0, gap_busy = 0, in_run1 = 0;
    logic [31:0] mcrc, mcrc1;
    logic [8:0]  exp_w;

    always @(negedge phy_tx_clk) begin
        if (sys_rst) begin
            in_run = 0; have_prev = 0; run_len = 0; gap_len = 0; in_run1 = 0;
        end else begin
            if (tx_und0) und_cnt++;
            if (tx_er0 && !tx_en0) stray_er++;
            if (tx_en0) begin
                if (!in_run) begin
                    if (have_prev) begin
                        gap_q.push_back(gap_len);
                        gap_busy_q.push_back(int'(gap_busy));
                    end
                    in_run = 1; run_len = 0; er_in_run = 0; mcrc = 32'hFFFFFFFF;
                end
                if (tx_er0) begin
                    er_in_run = 1;
                    check_val("underrun_pulse", 32'(tx_und0), 32'd1);
                end
                if (exp_q.size() == 0) check_val("sb_has_expect", 32'd0, 32'd1);
                else begin
                    exp_w = exp_q.pop_front();
                    check_val("line_byte", {23'd0, tx_er0, txd0}, {23'd0, exp_w});
                end
                if (run_len >= 8) mcrc = crc_step(mcrc, txd0);
                run_len++;
            end else begin
                if (in_run) begin
                    in_run = 0;
                    run_q.push_back(run_len);
                    if (!er_in_run) check_val("fcs_residue", mcrc, 32'hC704DD7B);
                    have_prev = 1; gap_len = 0; gap_busy = 1;
                end
                gap_len++;
                if (!tx_busy0) gap_busy = 0;
            end
            if (tx_en1) begin
                if (!in_run1) begin in_run1 = 1; run_len1 = 0; mcrc1 = 32'hFFFFFFFF; end
                if (run_len1 >= 8) mcrc1 = crc_step(mcrc1, txd1);
                run_len1++;
            end else if (in_run1) begin
                in_run1 = 0;
                run1_q.push_back(run_len1);
                check_val("np_fcs_residue", mcrc1, 32'hC704DD7B);
            end
        end
    end

    task automatic tick();
        @(negedge phy_tx_clk);
        #1;
    endtask

    task automatic push0(input logic [8:0] w);
        mem0[t0[9:0]] = w;
        t0 = t0 + 1;
    endtask

    task automatic make_payload(input int n, input bit rnd);
        pl.delete();
        for (int i = 0; i < n; i++) pl.push_back(rnd ? 8'($urandom_range(0, 255)) : 8'(i));
    endtask

    task automatic expect_frame();
        logic [7:0]  b[$];
        logic [31:0] c;
        b = pl;
        while (b.size() < 60) b.push_back(8'h00);
        for (int i = 0; i < 7; i++) exp_q.push_back(9'h055);
        exp_q.push_back(9'h0D5);
        c = 32'hFFFFFFFF;
        foreach (b[i]) begin
            c = crc_step(c, b[i]);
            exp_q.push_back({1'b0, b[i]});
        end
        c = ~c;
        for (int k = 0; k < 4; k++) exp_q.push_back({1'b0, rev8(c[31-8*k -: 8])});
    endtask

    task automatic send0();
        expect_frame();
        foreach (pl[i]) push0({1'b1, pl[i]});
        push0(9'h000);
    endtask

    task automatic wait_done();
        bit done;
        done = 0;
        for (int k = 0; k < 3000 && !done; k++) begin
            tick();
            if (exp_q.size() == 0 && !tx_busy0 && h0 == t0 && !tx_busy1 && h1 == t1) done = 1;
        end
        check_val("completion", 32'(done), 32'd1);
    endtask

    int rb, ub, nr, gb;
    bit got;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        sys_rst = 1'b1;
        tick();
        check_val("rst_tx_en", 32'(tx_en0), 32'd0);
        check_val("rst_tx_er", 32'(tx_er0), 32'd0);
        check_val("rst_txd", 32'(txd0), 32'd0);
        check_val("rst_busy", 32'(tx_busy0), 32'd0);
        check_val("rst_underrun", 32'(tx_und0), 32'd0);
        check_val("rst_rd_en", 32'(rd_en0), 32'd0);
        tick(); tick();
        sys_rst = 1'b0;
        tick();

        rb = rd_cnt0;
        make_payload(60, 1'b0);
        send0();
        wait_done();
        check_val("f60_len", run_q[$], 72);
        check_val("f60_rd_en", rd_cnt0 - rb, 61);

        make_payload(14, 1'b1);
        send0();
        foreach (pl[i]) begin mem1[t1[9:0]] = {1'b1, pl[i]}; t1 = t1 + 1; end
        mem1[t1[9:0]] = 9'h000; t1 = t1 + 1;
        wait_done();
        check_val("f14_pad_len", run_q[$], 72);
        check_val("f14_nopad_len", run1_q[$], 26);

        rb = rd_cnt0;
        nr = run_q.size();
        push0(9'h0A5);
        repeat (5) tick();
        check_val("stray_pop", rd_cnt0 - rb, 1);
        check_val("stray_no_frame", run_q.size(), nr);
        check_val("stray_busy", 32'(tx_busy0), 32'd0);
        make_payload(30, 1'b1);
        send0();
        wait_done();
        check_val("after_stray_len", run_q[$], 72);
        check_val("after_stray_rd_en", rd_cnt0 - rb, 32);

        gb = gap_q.size();
        make_payload(64, 1'b1); send0();
        make_payload(64, 1'b1); send0();
        wait_done();
        check_val("b2b_len_a", run_q[$-1], 76);
        check_val("b2b_len_b", run_q[$], 76);
        check_val("b2b_gap_count", gap_q.size() - gb, 2);
        check_val("b2b_gap", gap_q[$], 12);
        check_val("b2b_busy_held", gap_busy_q[$], 1);

        rb = rd_cnt0;
        ub = und_cnt;
        make_payload(20, 1'b1);
        for (int i = 0; i < 7; i++) exp_q.push_back(9'h055);
        exp_q.push_back(9'h0D5);
        foreach (pl[i]) begin
            exp_q.push_back({1'b0, pl[i]});
            push0({1'b1, pl[i]});
        end
        exp_q.push_back(9'h100);
        got = 0;
        for (int k = 0; k < 300 && !got; k++) begin
            tick();
            if (und_cnt > ub) got = 1;
        end
        check_val("underrun_seen", 32'(got), 32'd1);
        repeat (5) tick();
        check_val("drain_line_idle", 32'(tx_en0), 32'd0);
        check_val("drain_busy", 32'(tx_busy0), 32'd1);
        for (int i = 0; i < 10; i++) push0({1'b1, 8'($urandom_range(0, 255))});
        push0(9'h000);
        make_payload(40, 1'b1);
        send0();
        wait_done();
        check_val("underrun_len", run_q[$-1], 29);
        check_val("post_underrun_len", run_q[$], 72);
        check_val("post_underrun_gap_ge_ifg", 32'(gap_q[$] >= 12), 32'd1);
        check_val("underrun_rd_en", rd_cnt0 - rb, 72);
        check_val("underrun_pulses", und_cnt - ub, 1);

        make_payload(60, 1'b1);
        send0();
        got = 0;
        for (int k = 0; k < 300 && !got; k++) begin
            tick();
            if (in_run && run_len >= 30) got = 1;
        end
        check_val("mid_data_reached", 32'(got), 32'd1);
        sys_rst = 1'b1;
        tick();
        check_val("midrst_tx_en", 32'(tx_en0), 32'd0);
        check_val("midrst_tx_er", 32'(tx_er0), 32'd0);
        check_val("midrst_txd", 32'(txd0), 32'd0);
        check_val("midrst_busy", 32'(tx_busy0), 32'd0);
        tick();
        exp_q.delete();
        sys_rst = 1'b0;
        tick();
        make_payload(50, 1'b1);
        send0();
        wait_done();
        check_val("post_rst_len", run_q[$], 72);
        check_val("stray_tx_er", stray_er, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
